// File: rtl/pvar_pkg.sv
// pvar_pkg: shared types and helpers for the pvar_delay_pipe delay pipe.
// Provides the mode encoding, the occupancy-counter width helper and a
// half-swap helper usable for any even data width up to PV_MAX_W.
package pvar_pkg;

    typedef enum logic [1:0] {
        PV_SHIFT = 2'b00,
        PV_HOLD  = 2'b01,
        PV_SWAP  = 2'b10,
        PV_FLUSH = 2'b11
    } pvar_mode_e;

    // Widest data path the swap helper supports.
    localparam int PV_MAX_W = 64;

    // Bits needed to count 0..depth set valid bits.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Exchanges the upper and lower w/2 bits of the low w bits of x.
    function automatic logic [PV_MAX_W-1:0] swap_halves(input logic [PV_MAX_W-1:0] x,
                                                        input int w);
        logic [PV_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < PV_MAX_W / 2; i++) begin
            if (i < w / 2) begin
                r[i]         = x[i + w / 2];
                r[i + w / 2] = x[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pvar_stage.sv
// pvar_stage: one data+valid register of the delay pipe.
// load copies the upstream sample in; clear (when not loading) drops the
// valid bit but keeps the data; reset returns the stage to {INIT, invalid}.
module pvar_stage #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d_in,
    input  logic             v_in,
    output logic [WIDTH-1:0] d_out,
    output logic             v_out
);

    logic [WIDTH-1:0] d_d, d_q;
    logic             v_d, v_q;

    // Next-state selection: load wins, clear only touches the valid bit.
    always_comb begin
        // NOTE: defaults first so every path assigns d_d/v_d and no latch is inferred.
        d_d = d_q;
        v_d = v_q;
        if (load) begin
            d_d = d_in;
            v_d = v_in;
        end else if (clear) begin
            v_d = 1'b0;
        end
    end

    // Stage register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking updates so every stage samples its neighbour's old value.
        if (!rst) begin
            d_q <= INIT;
            v_q <= 1'b0;
        end else begin
            d_q <= d_d;
            v_q <= v_d;
        end
    end

    assign d_out = d_q;
    assign v_out = v_q;

endmodule

// File: rtl/pvar_delay_pipe.sv
// pvar_delay_pipe: DEPTH-stage, WIDTH-bit delay pipe with per-stage valid
// bits and a 2-bit mode (SHIFT, HOLD, SWAP, FLUSH).  cont drops to 0 for the
// cycle following a FLUSH edge.
// Optional: define PVAR_DELAY_OCC_EN to add the occupancy counter and the
// occ_out / empty ports.
module pvar_delay_pipe
    import pvar_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [1:0]                 mode,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
`ifdef PVAR_DELAY_OCC_EN
    output logic [occ_w(DEPTH)-1:0]    occ_out,
    output logic                       empty,
`endif
    output logic                       cont
);

    if ((WIDTH < 2) || (WIDTH % 2 != 0) || (WIDTH > PV_MAX_W)) begin : g_bad_width
        $error("pvar_delay_pipe: WIDTH must be even, >= 2 and <= PV_MAX_W");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("pvar_delay_pipe: DEPTH must be >= 1");
    end

    pvar_mode_e mode_e;
    logic       load;
    logic       clear;
    logic [WIDTH-1:0] stage0_d;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;
    logic [DEPTH-1:0]            stage_v;
    logic cont_d, cont_q;

    assign mode_e = pvar_mode_e'(mode);
    assign load   = (mode_e == PV_SHIFT) || (mode_e == PV_SWAP);
    assign clear  = (mode_e == PV_FLUSH);

    // Entering sample: halves swapped only in SWAP mode.
    always_comb begin
        stage0_d = in_data;
        if (mode_e == PV_SWAP) begin
            stage0_d = WIDTH'(swap_halves(PV_MAX_W'(in_data), WIDTH));
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] din;
        logic             vin;
        if (i == 0) begin : g_head
            assign din = stage0_d;
            assign vin = in_valid;
        end else begin : g_body
            assign din = stage_d[i-1];
            assign vin = stage_v[i-1];
        end
        pvar_stage #(
            .WIDTH (WIDTH),
            .INIT  (INIT)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .load  (load),
            .clear (clear),
            .d_in  (din),
            .v_in  (vin),
            .d_out (stage_d[i]),
            .v_out (stage_v[i])
        );
    end

    // Continue flag is low only after an edge that saw FLUSH.
    always_comb begin
        cont_d = (mode_e != PV_FLUSH);
    end

    // Continue flag register, set under reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cont_q <= 1'b1;
        end else begin
            cont_q <= cont_d;
        end
    end

    assign out_data  = stage_d[DEPTH-1];
    assign out_valid = stage_v[DEPTH-1];
    assign cont      = cont_q;

`ifdef PVAR_DELAY_OCC_EN
    localparam int OCC_W = occ_w(DEPTH);

    logic [OCC_W-1:0] occ_d, occ_q;

    // Occupancy tracks entering minus leaving valid samples.
    always_comb begin
        occ_d = occ_q;
        case (mode_e)
            PV_SHIFT, PV_SWAP: occ_d = occ_q + OCC_W'(in_valid) - OCC_W'(stage_v[DEPTH-1]);
            PV_FLUSH:          occ_d = '0;
            default:           occ_d = occ_q;
        endcase
    end

    // Occupancy register, cleared under reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ_out = occ_q;
    assign empty   = (occ_q == '0);
`endif

endmodule

// File: tb/tb_pvar_delay_pipe.sv
// Testbench for pvar_delay_pipe: a WIDTH=8/DEPTH=4/INIT=A5 instance and a
// WIDTH=2/DEPTH=1/INIT=01 instance share clock, reset and mode; both are
// compared every cycle against queue-based reference models.
module tb_pvar_delay_pipe;
    import pvar_pkg::*;

    localparam int         DA     = 4;
    localparam logic [7:0] INIT_A = 8'hA5;
    localparam logic [1:0] INIT_B = 2'b01;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       a_out_valid, a_cont;
    logic [7:0] a_out_data;
    logic       b_out_valid, b_cont;
    logic [1:0] b_out_data;
`ifdef PVAR_DELAY_OCC_EN
    logic [2:0] a_occ;
    logic       a_empty;
    logic [0:0] b_occ;
    logic       b_empty;
`endif

    pvar_delay_pipe #(.WIDTH(8), .DEPTH(DA), .INIT(INIT_A)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .mode      (mode),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
`ifdef PVAR_DELAY_OCC_EN
        .occ_out   (a_occ),
        .empty     (a_empty),
`endif
        .cont      (a_cont)
    );

    pvar_delay_pipe #(.WIDTH(2), .DEPTH(1), .INIT(INIT_B)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data[1:0]),
        .mode      (mode),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
`ifdef PVAR_DELAY_OCC_EN
        .occ_out   (b_occ),
        .empty     (b_empty),
`endif
        .cont      (b_cont)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of everything that entered, newest at index 0.
    typedef struct packed { logic v; logic [7:0] d; } ent_a_t;
    typedef struct packed { logic v; logic [1:0] d; } ent_b_t;
    ent_a_t qa[$];
    ent_b_t qb[$];
    logic   m_cont;

    task automatic model_reset();
        qa.delete();
        qb.delete();
        for (int i = 0; i < DA; i++) qa.push_back('{v: 1'b0, d: INIT_A});
        qb.push_back('{v: 1'b0, d: INIT_B});
        m_cont = 1'b1;
    endtask

    task automatic model_edge();
        ent_a_t ea;
        ent_b_t eb;
        case (mode)
            2'b00, 2'b10: begin
                ea.v = in_valid;
                ea.d = (mode == 2'b10) ? {in_data[3:0], in_data[7:4]} : in_data;
                eb.v = in_valid;
                eb.d = (mode == 2'b10) ? {in_data[0], in_data[1]} : in_data[1:0];
                qa.push_front(ea);
                void'(qa.pop_back());
                qb.push_front(eb);
                void'(qb.pop_back());
            end
            2'b11: begin
                for (int i = 0; i < qa.size(); i++) begin
                    ea = qa[i];
                    ea.v = 1'b0;
                    qa[i] = ea;
                end
                eb = qb[0];
                eb.v = 1'b0;
                qb[0] = eb;
            end
            default: ;
        endcase
        m_cont = (mode != 2'b11);
    endtask

    task automatic compare();
        ent_a_t oa;
        ent_b_t ob;
        int     cnt;
        oa = qa[DA-1];
        ob = qb[0];
        check("a_valid", 32'(a_out_valid), 32'(oa.v));
        if (oa.v) check("a_data", 32'(a_out_data), 32'(oa.d));
        check("a_cont", 32'(a_cont), 32'(m_cont));
        check("b_valid", 32'(b_out_valid), 32'(ob.v));
        if (ob.v) check("b_data", 32'(b_out_data), 32'(ob.d));
        check("b_cont", 32'(b_cont), 32'(m_cont));
        cnt = 0;
        for (int i = 0; i < DA; i++) if (qa[i].v) cnt++;
`ifdef PVAR_DELAY_OCC_EN
        check("a_occ", 32'(a_occ), 32'(cnt));
        check("a_empty", 32'(a_empty), 32'(cnt == 0));
        check("b_occ", 32'(b_occ), 32'(ob.v));
        check("b_empty", 32'(b_empty), 32'(!ob.v));
`else
        if (cnt > DA) check("model_occ_range", 32'(cnt), 32'(DA));
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_data"}, 32'(a_out_data), 32'(INIT_A));
        check({tag, "_a_valid"}, 32'(a_out_valid), 32'd0);
        check({tag, "_a_cont"}, 32'(a_cont), 32'd1);
        check({tag, "_b_data"}, 32'(b_out_data), 32'(INIT_B));
        check({tag, "_b_valid"}, 32'(b_out_valid), 32'd0);
`ifdef PVAR_DELAY_OCC_EN
        check({tag, "_a_occ"}, 32'(a_occ), 32'd0);
        check({tag, "_a_empty"}, 32'(a_empty), 32'd1);
`endif
    endtask

    task automatic step(input logic [1:0] m, input logic v, input logic [7:0] dat);
        mode     = m;
        in_valid = v;
        in_data  = dat;
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    initial begin
        int r;
        // Reset held for three edges, then released mid-cycle.
        rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_release");

        // Latency: four consecutive samples, first emerges after the 4th edge.
        step(2'b00, 1'b1, 8'h11);
        check("b_lat1_data", 32'(b_out_data), 32'h1);
        step(2'b00, 1'b1, 8'h22);
        check("b_lat1_data_10", 32'(b_out_data), 32'h2);
        step(2'b00, 1'b1, 8'h33);
        step(2'b00, 1'b1, 8'h44);
        check("lat_11_valid", 32'(a_out_valid), 32'd1);
        check("lat_11_data", 32'(a_out_data), 32'h11);
`ifdef PVAR_DELAY_OCC_EN
        check("lat_full_occ", 32'(a_occ), 32'd4);
`endif
        step(2'b00, 1'b0, 8'h00);
        check("lat_22", 32'(a_out_data), 32'h22);
        step(2'b00, 1'b0, 8'h00);
        check("lat_33", 32'(a_out_data), 32'h33);
        step(2'b00, 1'b0, 8'h00);
        check("lat_44", 32'(a_out_data), 32'h44);

        // Swap affects only the entering sample.
        step(2'b10, 1'b1, 8'h3C);
        step(2'b00, 1'b1, 8'h3C);
        step(2'b00, 1'b0, 8'h00);
        step(2'b00, 1'b0, 8'h00);
        check("swap_c3", 32'(a_out_data), 32'hC3);
        step(2'b00, 1'b0, 8'h00);
        check("swap_3c", 32'(a_out_data), 32'h3C);

        // Hold: two samples parked for five edges, inputs ignored.
        step(2'b00, 1'b1, 8'h55);
        step(2'b00, 1'b1, 8'h66);
        for (int i = 0; i < 5; i++) begin
            step(2'b01, 1'b1, 8'hFF);
            check("hold_valid", 32'(a_out_valid), 32'd0);
`ifdef PVAR_DELAY_OCC_EN
            check("hold_occ", 32'(a_occ), 32'd2);
`endif
        end
        step(2'b00, 1'b0, 8'h00);
        step(2'b00, 1'b0, 8'h00);
        check("hold_resume_55", 32'(a_out_data), 32'h55);
        check("hold_resume_v", 32'(a_out_valid), 32'd1);

        // Flush a full pipe, then refill.
        step(2'b00, 1'b1, 8'hA1);
        step(2'b00, 1'b1, 8'hA2);
        step(2'b00, 1'b1, 8'hA3);
        step(2'b00, 1'b1, 8'hA4);
        step(2'b11, 1'b1, 8'h77);
        check("flush_valid", 32'(a_out_valid), 32'd0);
        check("flush_cont", 32'(a_cont), 32'd0);
`ifdef PVAR_DELAY_OCC_EN
        check("flush_occ", 32'(a_occ), 32'd0);
        check("flush_empty", 32'(a_empty), 32'd1);
`endif
        step(2'b00, 1'b1, 8'h88);
        check("flush_cont_back", 32'(a_cont), 32'd1);
        step(2'b00, 1'b0, 8'h00);
        step(2'b00, 1'b0, 8'h00);
        step(2'b00, 1'b0, 8'h00);
        check("flush_refill_88", 32'(a_out_data), 32'h88);
        step(2'b11, 1'b0, 8'h00);
        step(2'b11, 1'b0, 8'h00);
        check("flush_b2b_cont", 32'(a_cont), 32'd0);
        step(2'b00, 1'b0, 8'h00);
        check("flush_b2b_back", 32'(a_cont), 32'd1);

        // Randomized traffic with occasional asynchronous reset mid-stream.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0;
                #1;
                model_reset();
                check_reset_outputs("rst_async");
                @(negedge clk);
                rst = 1'b1;
            end else begin
                r = int'($urandom_range(0, 9));
                step((r < 5) ? 2'b00 : (r < 7) ? 2'b10 : (r < 9) ? 2'b01 : 2'b11,
                     1'($urandom_range(0, 1)), 8'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pvar_delay_pipe.md
Name: pvar_delay_pipe

Overview:
- Parametrised successor of the 1-bit single-state reactive step machine.
- Generalises the state to a DEPTH-stage, WIDTH-bit delay pipe with per-stage valid bits.
- Adds a 2-bit mode input: shift, hold, swap-halves, flush.
- Keeps the continue-flag output convention of the generated reactive blocks.
- Sits between a producer and a consumer that tolerate a fixed, known latency.

Parameters:
- WIDTH, 8, data width in bits; must be even and ≥2 (elaboration-time assertion).
- DEPTH, 4, number of pipe stages; must be ≥1 (DEPTH=1 is the single-state case).
- INIT, '0, WIDTH-bit value loaded into every stage data register on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  qualifies in_data.
- in_data  input  WIDTH  sample presented to stage 0.
- mode  input  2  00 SHIFT, 01 HOLD, 10 SWAP, 11 FLUSH; sampled every clk edge.
- out_valid  output  1  valid bit of stage DEPTH-1.
- out_data  output  WIDTH  data of stage DEPTH-1 (direct register output, no logic after it).
- cont  output  1  continue flag; 0 only in the cycle after a FLUSH edge.

Behaviour:
- State:
  - d[0..DEPTH-1] (WIDTH bits each), v[0..DEPTH-1] (1 bit each), cont_q.
  - occ, $clog2(DEPTH+1) bits, counts the set v bits.
- Reset (rst=0, asynchronous, overrides everything):
  - d[i]=INIT, v[i]=0, occ=0, cont_q=1.
  - Outputs during and after reset: out_valid=0, out_data=INIT, cont=1.
  - Reset mid-operation discards all in-flight samples; first edge after release acts on the current mode.
- SHIFT (00), per rising edge:
  - d[0]<=in_data; v[0]<=in_valid.
  - d[i]<=d[i-1]; v[i]<=v[i-1] for i≥1.
  - occ<=occ+in_valid-v[DEPTH-1].
- SWAP (10): same as SHIFT, except d[0]<={in_data[WIDTH/2-1:0], in_data[WIDTH-1:WIDTH/2]}. Only the entering sample is swapped.
- HOLD (01):
  - All d, v and occ keep their values; in_valid and in_data are ignored.
  - Outputs stay stable for as long as HOLD is applied.
- FLUSH (11):
  - All v<=0 and occ<=0; d keeps its values (out_data is don't-care while out_valid=0).
  - cont_q<=0 for exactly one cycle, then returns to 1 on the next non-FLUSH edge.
  - Back-to-back FLUSH edges keep cont at 0.
  - The input sample is dropped.
- Latency:
  - A sample captured in SHIFT/SWAP at edge k appears on out_data/out_valid after edge k+DEPTH-1.
  - This equals DEPTH edges from presentation, counting the capture edge as edge 1.
  - Each HOLD edge in between extends the latency by one.
- Gaps: a sample with in_valid=0 still shifts; it creates a bubble with v=0 and its d contents are don't-care.
- Boundaries:
  - occ saturates naturally in the range 0..DEPTH.
  - occ=DEPTH with in_valid=1 in SHIFT: the oldest sample leaves and the new one enters; occ stays at DEPTH.
  - There is no backpressure; the consumer must accept out_valid samples every cycle.

Optional Feature:
- PVAR_DELAY_OCC_EN defined:
  - Adds output port occ_out, $clog2(DEPTH+1) bits, driven directly from the occ register.
  - Adds output empty=(occ==0), 1 bit.
  - Both are 0/1 respectively under reset.
- Undefined: the occ register and both ports are absent; all other behaviour is identical.

Decomposition:
- Package pvar_pkg:
  - typedef enum logic [1:0] pvar_mode_e {PV_SHIFT, PV_HOLD, PV_SWAP, PV_FLUSH}.
  - Function occ_w(depth) returning $clog2(depth+1).
  - Function swap_halves for parametric width.
- Sub-module pvar_stage:
  - One WIDTH+1-bit register stage with load-enable (SHIFT/SWAP), valid-clear (FLUSH) and async active-low reset to {INIT, 0}.
  - The top module instantiates DEPTH of them in a generate loop.

Test Plan:
- Reset: WIDTH=8, DEPTH=4, INIT=8'hA5. Hold rst=0 for 3 cycles → out_data=8'hA5, out_valid=0, cont=1; release rst mid-cycle → no output change until the next edge.
- Latency: SHIFT, in_data=8'h11/22/33/44 with in_valid=1 on consecutive edges → 8'h11 with out_valid=1 after the 4th edge, then 22, 33, 44 on successive edges.
- Swap: SWAP with in_data=8'h3C → out_data=8'hC3 after 4 edges; following SHIFT sample 8'h3C emerges unchanged.
- Hold: load 2 samples, apply HOLD for 5 edges with in_valid=1 → outputs unchanged and occ_out=2 (OCC_EN); resume SHIFT → remaining latency unchanged.
- Flush: full pipe (occ=4), one FLUSH edge → out_valid=0 next cycle, cont=0 for one cycle, occ=0, empty=1; next SHIFT sample appears after DEPTH edges.
- Parametric corners:
  - DEPTH=1, WIDTH=2, INIT=2'b01: in_data=2'b10 appears after 1 edge.
  - Assert rst=0 mid-stream → immediate out_data=2'b01, out_valid=0.
